// File: rtl/dmem_image_loader_pkg.sv
// -----------------------------------------------------------------------------
// dmem_image_loader_pkg
// Shared constants for the data-memory image loader, the dmem wrapper and the
// bench: memory geometry, linear word-index split, loader FSM encodings and a
// helper that tells which states accept stream bytes.
// -----------------------------------------------------------------------------
package dmem_image_loader_pkg;

  localparam int BANKS      = 64;
  localparam int BANK_DEPTH = 512;
  localparam int DATA_W     = 32;
  localparam int IDX_W      = 15;
  localparam int ADDR_W     = 9;              // word address bits within a bank
  localparam int BANK_W     = IDX_W - ADDR_W; // bank select bits

  localparam logic [31:0] MAX_WORDS = 32'd32768;

  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

  // Loader FSM encodings
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LEN   = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_CHK   = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;
  localparam logic [2:0] ST_ERR   = 3'd6;

  // States in which the loader pulls bytes from the stream.
  function automatic logic stream_state(input logic [2:0] st);
    logic res;
    case (st)
      ST_LEN, ST_DATA, ST_CHK: res = 1'b1;
      default:                 res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dmem_image_loader_word_asm.sv
// -----------------------------------------------------------------------------
// dmem_image_loader_word_asm
// Big-endian 4-byte word assembler used for the length, data and checksum
// fields. The first accepted byte lands in [31:24]. word_o is the complete word
// including the byte being accepted right now, so word_ready_o (high on the
// 4th accepted byte) and word_o can be consumed on the same clock edge.
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-low reset
//   clr_i         synchronous clear of byte counter and partial word
//   byte_valid_i  a byte is accepted this cycle
//   byte_i        accepted byte
//   word_o        assembled word (valid when word_ready_o is high)
//   word_ready_o  pulse: 4th byte of a word accepted this cycle
// -----------------------------------------------------------------------------
module dmem_image_loader_word_asm (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_ready_o
);

  // Only the first three bytes need storage; the fourth is taken live.
  logic [23:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;

  // Next-state for the partial word and byte counter
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clr_i) begin
      shift_d = 24'h00_0000;
      cnt_d   = 2'd0;
    end else if (byte_valid_i) begin
      shift_d = {shift_q[15:0], byte_i};
      cnt_d   = cnt_q + 2'd1;  // wraps to 0 after the 4th byte
    end else begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
    end
  end

  // Partial word and byte counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= 24'h00_0000;
      cnt_q   <= 2'd0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign word_o       = {shift_q, byte_i};
  assign word_ready_o = byte_valid_i & ~clr_i & (cnt_q == 2'd3);

endmodule

// File: rtl/dmem_image_loader.sv
// -----------------------------------------------------------------------------
// dmem_image_loader
// Fills the 64-bank x 512-word data memory from a byte stream and keeps the
// core in reset until a complete, checksum-verified image has been written.
// Image: 4-byte word count N, N 32-bit words, 4-byte XOR checksum, all MSB
// byte first. Words go to linear index 0..N-1, split as bank = idx[14:9],
// addr = idx[8:0].
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   start      one-cycle pulse, begins a load (honoured in IDLE/DONE/ERR)
//   in_valid   byte available on in_data
//   in_data    stream byte
//   in_ready   loader accepts the byte this cycle
//   mem_we     one-cycle dmem write strobe
//   mem_bank   dmem bank select
//   mem_addr   word address within the bank
//   mem_wdata  word to write
//   cpu_hold   holds the core in reset while high
//   done       image loaded and verified
//   err        length overflow or checksum mismatch
// -----------------------------------------------------------------------------
module dmem_image_loader
  import dmem_image_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [BANK_W-1:0] mem_bank,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  logic [2:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  last_q, last_d;      // N-1, index of the final word
  logic [31:0]       chk_q, chk_d;        // running XOR of written words
  logic              in_ready_q, in_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [BANK_W-1:0] mem_bank_q, mem_bank_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              xfer_s;
  logic              asm_clr_s;
  logic [31:0]       asm_word_s;
  logic              asm_ready_s;

  // A byte is consumed only when the registered ready is presented.
  assign xfer_s = in_valid & in_ready_q;

  dmem_image_loader_word_asm u_word_asm (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (asm_clr_s),
    .byte_valid_i (xfer_s),
    .byte_i       (in_data),
    .word_o       (asm_word_s),
    .word_ready_o (asm_ready_s)
  );

  // FSM next-state and datapath next values
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    last_d      = last_q;
    chk_d       = chk_q;
    mem_we_d    = 1'b0;
    mem_bank_d  = mem_bank_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    asm_clr_s   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d   = ST_LEN;
          idx_d     = IDX_ZERO;
          chk_d     = 32'h0000_0000;
          asm_clr_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_LEN: begin
        if (asm_ready_s) begin
          // Truncated N-1; N = 32768 yields 32767, the last legal index.
          last_d = asm_word_s[IDX_W-1:0] - IDX_ONE;
          if (asm_word_s == 32'h0000_0000) begin
            state_d = ST_CHK;
          end else if (asm_word_s > MAX_WORDS) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_LEN;
        end
      end
      ST_DATA: begin
        if (asm_ready_s) begin
          // Outputs are registered, so the strobe is set up on entry to WRITE.
          state_d     = ST_WRITE;
          mem_we_d    = 1'b1;
          mem_wdata_d = asm_word_s;
          mem_bank_d  = idx_q[IDX_W-1:ADDR_W];
          mem_addr_d  = idx_q[ADDR_W-1:0];
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_WRITE: begin
        chk_d = chk_q ^ mem_wdata_q;
        idx_d = idx_q + IDX_ONE;
        if (idx_q == last_q) begin
          state_d = ST_CHK;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_CHK: begin
        if (asm_ready_s) begin
          if (asm_word_s == chk_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ERR;
          end
        end else begin
          state_d = ST_CHK;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status outputs follow the state being entered so they line up with it.
    in_ready_d = stream_state(state_d);
    done_d     = (state_d == ST_DONE);
    err_d      = (state_d == ST_ERR);
    cpu_hold_d = (state_d != ST_DONE);
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= IDX_ZERO;
      last_q      <= IDX_ZERO;
      chk_q       <= 32'h0000_0000;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_bank_q  <= {BANK_W{1'b0}};
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      cpu_hold_q  <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      chk_q       <= chk_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_bank_q  <= mem_bank_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_bank  = mem_bank_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_dmem_image_loader.sv
// -----------------------------------------------------------------------------
// tb_dmem_image_loader
// Directed bench for dmem_image_loader. Writes seen on the dmem port are
// logged on the falling clock edge and compared against hand-computed values.
// -----------------------------------------------------------------------------
module tb_dmem_image_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [5:0]  mem_bank;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [5:0]  wb_log[$];
  logic [8:0]  wa_log[$];
  logic [31:0] wd_log[$];

  always #5 clk = ~clk;

  dmem_image_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_bank  (mem_bank),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .err       (err)
  );

  // Log every dmem write strobe
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wb_log.push_back(mem_bank);
      wa_log.push_back(mem_addr);
      wd_log.push_back(mem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wb_log.delete();
    wa_log.delete();
    wd_log.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t;
    @(negedge clk);
    if (gaps && ($urandom_range(0, 1) == 1)) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (in_ready !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) begin
      errors++;
      $error("FAIL send_timeout: in_ready low for %0d cycles, required high", t);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    send_byte(w[31:24], gaps);
    send_byte(w[23:16], gaps);
    send_byte(w[15:8], gaps);
    send_byte(w[7:0], gaps);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int t;
    t = 0;
    while (done !== 1'b1 && err !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_end_timeout"}, (t < 20) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    logic [31:0] xsum;
    int bad;

    rst      = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #22 rst = 1'b1;

    // ---- Reset, no start ----
    repeat (6) @(negedge clk);
    check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_done",     {31'd0, done},     32'd0);
    check("rst_err",      {31'd0, err},      32'd0);
    check("rst_wdata",    mem_wdata,         32'd0);
    check("rst_bankaddr", {17'd0, mem_bank, mem_addr}, 32'd0);
    check("rst_no_we",    wd_log.size(),     32'd0);

    // ---- Good two-word image ----
    clear_log();
    pulse_start();
    check("len_in_ready", {31'd0, in_ready}, 32'd1);
    send_word(32'h0000_0002, 1'b0);
    send_word(32'hDEAD_BEEF, 1'b0);
    send_word(32'h0123_4567, 1'b0);
    send_word(32'hDF8E_FB88, 1'b0);   // DEADBEEF ^ 01234567
    wait_end("good");
    check("good_done",     {31'd0, done},     32'd1);
    check("good_err",      {31'd0, err},      32'd0);
    check("good_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    check("good_nwr",      wd_log.size(),     32'd2);
    if (wd_log.size() == 2) begin
      check("good_w0", {wb_log[0], wa_log[0]} , 15'd0);
      check("good_d0", wd_log[0], 32'hDEAD_BEEF);
      check("good_w1", {wb_log[1], wa_log[1]} , 15'd1);
      check("good_d1", wd_log[1], 32'h0123_4567);
    end
    // Bytes offered after DONE are refused
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (3) @(negedge clk);
    check("done_no_ready", {31'd0, in_ready}, 32'd0);
    check("done_stays",    {31'd0, done},     32'd1);
    in_valid = 1'b0;

    // ---- Same image, bad checksum ----
    clear_log();
    pulse_start();
    check("restart_done",     {31'd0, done},     32'd0);
    check("restart_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    send_word(32'h0000_0002, 1'b0);
    send_word(32'hDEAD_BEEF, 1'b0);
    send_word(32'h0123_4567, 1'b0);
    send_word(32'hDF8E_FB89, 1'b0);
    wait_end("badchk");
    check("badchk_err",      {31'd0, err},      32'd1);
    check("badchk_done",     {31'd0, done},     32'd0);
    check("badchk_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    check("badchk_nwr",      wd_log.size(),     32'd2);

    // ---- Length overflow: 32769 words ----
    clear_log();
    pulse_start();
    send_word(32'h0000_8001, 1'b0);
    check("ovf_err_now",  {31'd0, err},      32'd1);
    check("ovf_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (4) @(negedge clk);
    check("ovf_no_we",    wd_log.size(),     32'd0);

    // ---- Empty image: N = 0, checksum 0 ----
    clear_log();
    pulse_start();
    send_word(32'h0000_0000, 1'b0);
    send_word(32'h0000_0000, 1'b0);
    wait_end("empty");
    check("empty_done", {31'd0, done}, 32'd1);
    check("empty_nwr",  wd_log.size(), 32'd0);

    // ---- 513 words, value = index, random stream gaps ----
    clear_log();
    xsum = 32'h0000_0000;
    pulse_start();
    send_word(32'd513, 1'b1);
    for (int i = 0; i < 513; i++) begin
      send_word(32'(i), 1'b1);
      xsum ^= 32'(i);
    end
    check("big_xsum_model", xsum, 32'h0000_0200);  // XOR of 0..512 is 512
    send_word(xsum, 1'b1);
    wait_end("big");
    check("big_done", {31'd0, done}, 32'd1);
    check("big_nwr",  wd_log.size(), 32'd513);
    if (wd_log.size() == 513) begin
      bad = 0;
      for (int i = 0; i < 513; i++) begin
        if (wd_log[i] !== 32'(i) || {wb_log[i], wa_log[i]} !== 15'(i)) bad++;
      end
      check("big_words_bad", 32'(bad), 32'd0);
      check("big_last_bank", {26'd0, wb_log[512]}, 32'd1);
      check("big_last_addr", {23'd0, wa_log[512]}, 32'd0);
    end

    // ---- Async reset mid-DATA, then fresh single-word load ----
    clear_log();
    pulse_start();
    send_word(32'h0000_0003, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    #2 rst = 1'b0;
    #2;
    check("midrst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    check("midrst_done",     {31'd0, done},     32'd0);
    check("midrst_mem_we",   {31'd0, mem_we},   32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_idle_ready", {31'd0, in_ready}, 32'd0);
    check("midrst_no_we",      wd_log.size(),     32'd0);
    pulse_start();
    send_word(32'h0000_0001, 1'b0);
    send_word(32'h0000_0005, 1'b0);
    send_word(32'h0000_0005, 1'b0);
    wait_end("fresh");
    check("fresh_done",     {31'd0, done},     32'd1);
    check("fresh_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    check("fresh_nwr",      wd_log.size(),     32'd1);
    if (wd_log.size() == 1) begin
      check("fresh_loc",  {17'd0, wb_log[0], wa_log[0]}, 32'd0);
      check("fresh_data", wd_log[0], 32'h0000_0005);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
